scr_ram_arbiter: RTL and testbench
==================================

Name: scr_ram_arbiter

Overview:
- Shares the single-port screen RAM between two requesters:
  - The text renderer, which fetches character/colour byte pairs every pixel clock while active.
  - The host bus interface, which reads and writes screen contents.
- The renderer has absolute priority and is never stalled. Host accesses are buffered one-deep and issued in renderer-idle cycles.
- A starvation watchdog flags host requests held off too long.
- Sits between the renderer address generator, the host bus decoder and the screen RAM macro.

Parameters:
- ADDR_W, 13, screen RAM address width (5 bits row, 7 bits column, 1 bit char/colour select).
- DATA_W, 8, screen RAM data width.
- MAX_WAIT, 1023, host wait cycles before host_starved sets; minimum 1.
- WAIT_W, 10, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- ren_req  in  1  renderer wants a RAM read this cycle.
- ren_addr  in  ADDR_W  renderer read address.
- ren_valid  out  1  renderer read data valid (registered).
- ren_data  out  DATA_W  renderer read data; equals ram_rdata, meaningful only while ren_valid=1.
- host_req  in  1  host offers an access.
- host_ready  out  1  host request buffer empty; an access is accepted when host_req & host_ready.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rvalid  out  1  one-cycle pulse: host_rdata updated.
- host_rdata  out  DATA_W  last host read result (registered, held).
- host_done  out  1  one-cycle pulse in the cycle after any host access is issued to RAM.
- host_starved  out  1  sticky starvation flag.
- starve_clr  in  1  clears host_starved.
- ram_addr  out  ADDR_W  RAM address (combinational mux).
- ram_we  out  1  RAM write enable (combinational).
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after address.

Behaviour:
Reset (rst_n=0 at a rising edge):
- Pending buffer emptied; any buffered access is dropped and never issued.
- Wait counter = 0.
- Outputs: ren_valid=0, host_rvalid=0, host_done=0, host_rdata=0, host_starved=0.
- host_ready=1 in the first cycle after reset.
- ram_we=0 throughout the reset cycle.

Pending buffer:
- host_ready = !pend_valid.
- On host_req & host_ready: pend_valid, pend_we, pend_addr and pend_wdata load at that edge.
- Acceptance never depends on ren_req.

Grant, evaluated each cycle combinationally:
- REN: ren_req=1. ram_addr=ren_addr, ram_we=0.
- HOST: ren_req=0 & pend_valid=1. ram_addr=pend_addr, ram_we=pend_we, ram_wdata=pend_wdata.
- NONE: otherwise. ram_addr=ren_addr, ram_we=0.
- ram_wdata = pend_wdata at all times.

Latency:
- Renderer: REN grant in cycle N gives ren_valid=1 in N+1 (ren_valid is ren_req registered); ren_data = ram_rdata in N+1. Back-to-back every cycle is supported.
- Host write: issued in its HOST grant cycle N; host_done pulses in N+1.
- Host read: granted in N. At end of N+1, host_rdata <= ram_rdata. host_rvalid pulses in N+2. host_done pulses in N+1.
- pend_valid clears at the end of the HOST grant cycle, so host_ready=1 in N+1. The next access can be accepted in N+1 and issued in N+2 at the earliest (one host access per 2 cycles maximum).

Wait counter:
- Increments in each cycle with pend_valid & ren_req; saturates at MAX_WAIT.
- Clears to 0 at the end of a HOST grant cycle.
- host_starved sets at the edge where the counter transitions to MAX_WAIT. It stays set until starve_clr=1 or reset.
- If a set and starve_clr occur in the same cycle, set wins.

Boundary conditions:
- host_req while pend_valid=1: ignored; the host must hold the request until host_ready.
- ren_req falling in the same cycle the host is accepted: the grant happens no earlier than the next cycle.
- Address wrap: none; addresses pass through unmodified.
- Reset during the host read pipeline (between grant and rvalid): host_rvalid is not produced and host_rdata=0.

Test Plan:
- Reset with rst_n=0 for 2 cycles → host_ready=1, ren_valid=0, host_rdata=0x00, host_starved=0, ram_we=0.
- ren_req=1 continuously, ren_addr sweeping 0x0000..0x00FF; RAM model preloaded with data=addr[7:0] → ren_valid from cycle 1 after first request; every cycle ren_data equals the address issued the previous cycle; ram_we never 1.
- ren_req=0; host write addr 0x0102 data 0x41, then host read 0x0102 → write: ram_we=1 for exactly one cycle, host_done pulses in the cycle after. Read: host_rvalid pulses 2 cycles after its grant with host_rdata=0x41.
- ren_req=1 for 20 cycles with a host write pending at cycle 3 → host_ready=0 during cycles 4..20; write issued in the first cycle ren_req=0; host_ready=1 the next cycle; renderer sees no gap in ren_valid.
- MAX_WAIT=8, ren_req held high, one host access pending → host_starved=1 after 8 held-off cycles. It stays 1 after the access completes. starve_clr pulse → 0.
- Host read granted, then rst_n=0 in the following cycle → no host_rvalid pulse, host_rdata=0x00, host_ready=1 after reset.

Source files
------------

// File: rtl/scr_ram_arbiter.sv
// Screen RAM arbiter: renderer has absolute priority,
// host accesses are buffered one-deep and issued in idle cycles.
module scr_ram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 1023,
  parameter int WAIT_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_valid,
  output logic [DATA_W-1:0] ren_data,
  input  logic              host_req,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              host_starved,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [WAIT_W-1:0] MaxW = WAIT_W'(MAX_WAIT);

  logic              pend_valid_q;
  logic              pend_we_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_wdata_q;
  logic              ren_valid_q;
  logic              done_q;
  logic              rd_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              starved_q;
  logic              starved_d;
  logic              grant_host;
  logic              accept;

  // A buffered access is never issued while reset is asserted.
  assign grant_host = rst_n & ~ren_req & pend_valid_q;
  assign accept     = host_req & ~pend_valid_q;

  assign host_ready   = ~pend_valid_q;
  assign ram_addr     = grant_host ? pend_addr_q : ren_addr;
  assign ram_we       = grant_host & pend_we_q;
  assign ram_wdata    = pend_wdata_q;
  assign ren_valid    = ren_valid_q;
  assign ren_data     = ram_rdata;
  assign host_rvalid  = rvalid_q;
  assign host_rdata   = rdata_q;
  assign host_done    = done_q;
  assign host_starved = starved_q;

  // Saturating wait counter and sticky starvation flag.
  always_comb begin
    wait_d    = wait_q;
    starved_d = starved_q;
    if (grant_host) begin
      wait_d = '0;
    end else if (pend_valid_q && ren_req &&
                 wait_q != MaxW) begin
      wait_d = wait_q + 1'b1;
    end
    if (starve_clr) begin
      starved_d = 1'b0;
    end
    if (wait_d == MaxW && wait_q != MaxW) begin
      starved_d = 1'b1;
    end
  end

  // Pending host buffer: load on accept, empty on issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
      pend_we_q    <= host_we;
      pend_addr_q  <= host_addr;
      pend_wdata_q <= host_wdata;
    end else if (grant_host) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Response pipeline for renderer and host reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ren_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ren_valid_q <= ren_req;
      done_q      <= grant_host;
      rd_q        <= grant_host & ~pend_we_q;
      rvalid_q    <= rd_q;
      if (rd_q) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      starved_q <= starved_d;
    end
  end

endmodule

// File: tb/tb_scr_ram_arbiter.sv
// Scoreboard bench for scr_ram_arbiter with a
// synchronous RAM model; directed vectors.
module tb_scr_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren_req;
  logic [12:0] ren_addr;
  logic        ren_valid;
  logic [7:0]  ren_data;
  logic        host_req;
  logic        host_ready;
  logic        host_we;
  logic [12:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        host_done;
  logic        host_starved;
  logic        starve_clr;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0] mem     [0:8191];
  logic [7:0] exp_mem [0:8191];
  logic [7:0] ren_exp [$];
  logic [7:0] host_exp[$];

  int nvec     = 0;
  int nerr     = 0;
  int exp_done = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;

  scr_ram_arbiter #(
    .ADDR_W  (13),
    .DATA_W  (8),
    .MAX_WAIT(8),
    .WAIT_W  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ren_req     (ren_req),
    .ren_addr    (ren_addr),
    .ren_valid   (ren_valid),
    .ren_data    (ren_data),
    .host_req    (host_req),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_done   (host_done),
    .host_starved(host_starved),
    .starve_clr  (starve_clr),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_access(input logic        we,
                             input logic [12:0] a,
                             input logic [7:0]  d);
    int n = 0;
    while (!host_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("ready_timeout", host_ready, 1);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_req = 1'b0;
    exp_done++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ren_valid) begin
        if (ren_exp.size() == 0) chk("ren_extra", 1, 0);
        else chk("ren_data", ren_data, ren_exp.pop_front());
      end
      if (host_rvalid) begin
        if (host_exp.size() == 0) chk("host_extra", 1, 0);
        else chk("host_rdata", host_rdata,
                 host_exp.pop_front());
      end
      if (host_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = i[7:0];
      exp_mem[i] = i[7:0];
    end
    rst_n      = 1'b0;
    ren_req    = 1'b0;
    ren_addr   = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    starve_clr = 1'b0;

    // reset
    tick();
    chk("rst_ram_we", ram_we, 0);
    tick();
    chk("rst_ready", host_ready, 1);
    chk("rst_ren_valid", ren_valid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_starved", host_starved, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_done", host_done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // renderer sweep
    for (int i = 0; i < 256; i++) begin
      ren_req  = 1'b1;
      ren_addr = 13'(i);
      ren_exp.push_back(exp_mem[i]);
      #1;
      chk("sweep_we", ram_we, 0);
      if (i > 0) chk("sweep_valid", ren_valid, 1);
      tick();
    end
    ren_req = 1'b0;
    tick();

    // host write then read
    exp_mem[13'h102] = 8'h41;
    host_access(1'b1, 13'h102, 8'h41);
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 13'h102);
    chk("wr_wdata", ram_wdata, 8'h41);
    tick();
    chk("wr_we_off", ram_we, 0);
    chk("wr_done", host_done, 1);
    tick();
    chk("wr_done_off", host_done, 0);
    host_exp.push_back(exp_mem[13'h102]);
    host_access(1'b0, 13'h102, 8'h00);
    #1;
    chk("rd_we", ram_we, 0);
    chk("rd_addr", ram_addr, 13'h102);
    tick();
    chk("rd_done", host_done, 1);
    chk("rd_rvalid_n1", host_rvalid, 0);
    tick();
    chk("rd_rvalid_n2", host_rvalid, 1);
    chk("rd_data_n2", host_rdata, 8'h41);
    tick();
    chk("rd_rvalid_n3", host_rvalid, 0);

    // renderer busy 20 cycles, host write held off
    for (int c = 1; c <= 20; c++) begin
      ren_req  = 1'b1;
      ren_addr = 13'(13'h200 + c);
      ren_exp.push_back(exp_mem[13'h200 + c]);
      if (c == 3) begin
        chk("busy_ready_c3", host_ready, 1);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 13'h300;
        host_wdata = 8'h5A;
        exp_mem[13'h300] = 8'h5A;
        exp_done++;
      end
      if (c == 5) begin
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 13'h301;
        host_wdata = 8'h77;
      end
      if (c == 4 || c == 6) host_req = 1'b0;
      #1;
      if (c >= 4) chk("busy_ready", host_ready, 0);
      if (c >= 2) chk("busy_ren_valid", ren_valid, 1);
      chk("busy_we", ram_we, 0);
      if (c == 11) chk("starve_c11", host_starved, 0);
      if (c == 12) chk("starve_c12", host_starved, 1);
      tick();
    end
    ren_req = 1'b0;
    #1;
    chk("hold_we", ram_we, 1);
    chk("hold_addr", ram_addr, 13'h300);
    chk("hold_wdata", ram_wdata, 8'h5A);
    chk("hold_ren_valid", ren_valid, 1);
    tick();
    chk("hold_ready", host_ready, 1);
    chk("hold_done", host_done, 1);
    chk("hold_ren_off", ren_valid, 0);
    chk("starve_sticky", host_starved, 1);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    chk("starve_clr", host_starved, 0);

    host_exp.push_back(exp_mem[13'h300]);
    host_access(1'b0, 13'h300, 8'h00);
    repeat (3) tick();
    host_exp.push_back(exp_mem[13'h301]);
    host_access(1'b0, 13'h301, 8'h00);
    repeat (3) tick();

    // reset in the cycle after a read grant
    host_access(1'b0, 13'h102, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_rdata", host_rdata, 0);
    chk("rr_rvalid", host_rvalid, 0);
    chk("rr_ready", host_ready, 1);
    tick();
    chk("rr_rvalid_n", host_rvalid, 0);
    tick();
    tick();

    chk("ren_left", ren_exp.size(), 0);
    chk("host_left", host_exp.size(), 0);
    chk("done_count", done_cnt, exp_done);
    chk("final_starved", host_starved, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
